uart_nibble_rx: RTL and testbench
=================================

# uart_nibble_rx

Serial receive front end that feeds the `system` block's nibble input. Deserialises an 8N1 UART stream from the host, decodes each received character to a 4-bit value, and presents it on `w_RX_Byte` with a one-cycle `w_RX_DV` strobe, the exact pair `system` consumes. Framing errors and non-hex characters are reported on a separate error strobe and never produce `w_RX_DV`.

## Interface
- `CLKS_PER_BIT`, 434, clock cycles per UART bit (50 MHz / 115200); legal ≥ 4.
- `CLOCK_50`  in  1  system clock, all logic rising-edge.
- `KEY`  in  1  reset; asynchronous, active-low (0 = reset).
- `UART_RXD`  in  1  asynchronous serial line, idle high.
- `w_RX_Byte`  out  4  decoded nibble of the last valid character.
- `w_RX_DV`  out  1  one-cycle strobe: `w_RX_Byte` updated this cycle.
- `o_rx_err`  out  1  one-cycle strobe: framing error or rejected character.
- `o_busy`  out  1  high from start-bit detection until return to IDLE.

## Operation
- `UART_RXD` passes through a 2-FF synchroniser, reset to 1; all decisions use the synchronised value `rxd_s`.
- States: IDLE, START, DATA, STOP, DONE.
- IDLE: on `rxd_s`=0 → START, clear counter.
- START: count to `(CLKS_PER_BIT-1)/2` (integer division); sample there. If `rxd_s`=0 → DATA, else false start → IDLE with no strobe.
- DATA: every `CLKS_PER_BIT` cycles, sample one bit into the shift register, LSB first. After bit 7 → STOP.
- STOP: after `CLKS_PER_BIT` cycles, sample. If 1 → DONE with frame OK, else DONE with framing error.
- DONE: held for one cycle. It issues exactly one of `w_RX_DV` or `o_rx_err`, then → IDLE. A low line in DONE/IDLE is treated as a new start bit. There is no wait for a full stop bit.
- Bit counter is 3 bits. The clock counter is `$clog2(CLKS_PER_BIT)` bits and resets to 0 at each sample point.
- Decode under `UART_RX_ASCII_EN`:
  - '0'–'9' (0x30–0x39) → 0–9.
  - 'A'–'F' (0x41–0x46) and 'a'–'f' (0x61–0x66) → 10–15.
  - Any other byte → `o_rx_err`. `w_RX_Byte` is unchanged.
- Reset values: `w_RX_Byte`=0, `w_RX_DV`=0, `o_rx_err`=0, `o_busy`=0, state IDLE.
- `KEY` asserted mid-frame aborts immediately. No strobe is issued, and after release the block waits for a fresh falling edge.

## Timing
- Latency from sampling the stop bit to the strobe is 1 cycle. The strobe is registered and high for exactly one `CLOCK_50` cycle.
- Latency from the line's falling edge to START entry is 2 cycles (synchroniser) + 1.
- `w_RX_Byte` changes only in the cycle `w_RX_DV`=1 and holds until the next valid character.
- `w_RX_DV` and `o_rx_err` are never high in the same cycle.
- Back-to-back frames at full line rate must be received without loss. The minimum gap between strobes is `10*CLKS_PER_BIT - CLKS_PER_BIT/2` cycles.

## Configuration
- `UART_RX_ASCII_EN` defined: ASCII hex decode as above; non-hex bytes produce `o_rx_err`.
- Not defined: `w_RX_Byte` = received byte[3:0] verbatim. Every good frame produces `w_RX_DV`, and `o_rx_err` flags framing errors only.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum;
  - ASCII range constants (0x30, 0x39, 0x41, 0x46, 0x61, 0x66);
  - the default `CLKS_PER_BIT` constant.
- One sub-module, `hex_ascii_decode`. It is combinational: 8-bit in, 4-bit value plus valid out, and it is only instantiated when `UART_RX_ASCII_EN` is defined.
- Synchroniser, counters and FSM stay in the top module.

## Test plan
All scenarios use `CLKS_PER_BIT`=8 and `UART_RX_ASCII_EN` defined unless stated.
- Reset: hold `KEY`=0 with the line toggling → all outputs 0. After release, the line held high → no strobes for 200 cycles.
- Send 0x31 ('1'), then 0x32, then 0x33 back-to-back:
  - exactly three `w_RX_DV` pulses;
  - `w_RX_Byte`=1, 2, 3 in turn, each a single cycle;
  - `o_rx_err` never high.
- Send 0x61 ('a') → `w_RX_Byte`=0xA. Send 0x47 ('G') → `o_rx_err` pulse, no `w_RX_DV`, `w_RX_Byte` stays 0xA.
- Framing error: send 0x38 with stop bit = 0 → one `o_rx_err` pulse, no `w_RX_DV`. A following good 0x38 frame gives `w_RX_Byte`=8.
- Glitch and abort cases:
  - a 2-cycle low glitch on an idle line → no strobe, `o_busy` back to 0 within 5 cycles;
  - `KEY`=0 asserted during data bit 4 → immediate IDLE, no strobe.
- Macro undefined: send 0x47 → `w_RX_DV` with `w_RX_Byte`=0x7.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver state encoding, ASCII hex range limits and default bit period.
package uart_pkg;
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;
   localparam logic [7:0] ASCII_0  = 8'h30;
   localparam logic [7:0] ASCII_9  = 8'h39;
   localparam logic [7:0] ASCII_UA = 8'h41;
   localparam logic [7:0] ASCII_UF = 8'h46;
   localparam logic [7:0] ASCII_LA = 8'h61;
   localparam logic [7:0] ASCII_LF = 8'h66;
   localparam int CLKS_PER_BIT_DEF = 434;
endpackage

// File: rtl/hex_ascii_decode.sv
// hex_ascii_decode: combinational ASCII hex digit ('0'-'9', 'A'-'F', 'a'-'f') to 4-bit value.
module hex_ascii_decode
   import uart_pkg::*;
(
   input  logic [7:0] data,
   output logic [3:0] value,
   output logic       valid
);
   logic digit, alpha;
   assign digit = data >= ASCII_0 && data <= ASCII_9;
   assign alpha = (data >= ASCII_UA && data <= ASCII_UF) || (data >= ASCII_LA && data <= ASCII_LF);
   assign valid = digit || alpha;
   // letters sit at 0x?1..0x?6 in both cases, so the low nibble plus 9 gives 10..15
   assign value = digit ? data[3:0] : alpha ? data[3:0] + 4'd9 : 4'd0;
endmodule

// File: rtl/uart_nibble_rx.sv
// uart_nibble_rx: 8N1 UART receiver delivering one nibble per character with a one-cycle strobe.
// UART_RX_ASCII_EN selects ASCII hex decoding; otherwise the low nibble of each byte is passed through.
module uart_nibble_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic       CLOCK_50,
   input  logic       KEY,
   input  logic       UART_RXD,
   output logic [3:0] w_RX_Byte,
   output logic       w_RX_DV,
   output logic       o_rx_err,
   output logic       o_busy
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] TICK = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
`ifdef UART_RX_ASCII_EN
   localparam int DW = 8;
`else
   localparam int DW = 4;
`endif

   state_t          state, state_nx;
   logic            rxd_m, rxd_s;
   logic [CW-1:0]   clk_cnt;
   logic [2:0]      bit_cnt;
   logic [DW-1:0]   shreg;
   logic [3:0]      nib;
   logic            nib_ok, tick, stop_pt, good;

`ifdef UART_RX_ASCII_EN
   hex_ascii_decode u_dec (.data(shreg), .value(nib), .valid(nib_ok));
`else
   assign nib    = shreg;
   assign nib_ok = 1'b1;
`endif

   assign tick    = clk_cnt == TICK;
   assign stop_pt = state == STOP && tick;
   assign good    = rxd_s && nib_ok;
   assign o_busy  = state != IDLE;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = rxd_s ? IDLE : START;
         START:   if (clk_cnt == HALF) state_nx = rxd_s ? IDLE : DATA;
         DATA:    if (tick && bit_cnt == 3'd7) state_nx = STOP;
         STOP:    if (tick) state_nx = DONE;
         default: state_nx = rxd_s ? IDLE : START;
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge KEY) begin
      if (!KEY) begin
         state     <= IDLE;
         rxd_m     <= 1'b1;
         rxd_s     <= 1'b1;
         clk_cnt   <= '0;
         bit_cnt   <= '0;
         shreg     <= '0;
         w_RX_Byte <= '0;
         w_RX_DV   <= 1'b0;
         o_rx_err  <= 1'b0;
      end else begin
         state   <= state_nx;
         rxd_m   <= UART_RXD;
         rxd_s   <= rxd_m;
         clk_cnt <= (state == IDLE || state_nx != state || tick) ? '0 : clk_cnt + 1'b1;
         if (state == START) bit_cnt <= '0;
         // the raw build keeps only data bits 0..3
         if (state == DATA && tick) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (DW == 8 || !bit_cnt[2]) shreg[bit_cnt[$clog2(DW)-1:0]] <= rxd_s;
         end
         w_RX_DV  <= stop_pt && good;
         o_rx_err <= stop_pt && !good;
         if (stop_pt && good) w_RX_Byte <= nib;
      end
   end
endmodule

// File: tb/tb_uart_nibble_rx.sv
// tb_uart_nibble_rx: directed frame table plus reset, glitch and abort sequences at CLKS_PER_BIT=8.
module tb_uart_nibble_rx;
   localparam int CPB = 8;
`ifdef UART_RX_ASCII_EN
   localparam bit ASCII = 1'b1;
`else
   localparam bit ASCII = 1'b0;
`endif

   typedef struct {
      logic [7:0] data;
      bit         stop;
      bit         dv_a;
      logic [3:0] nib_a;
      bit         dv_r;
      logic [3:0] nib_r;
   } vec_t;
   typedef struct {
      bit         is_dv;
      logic [3:0] nib;
   } ev_t;

   logic       CLOCK_50 = 1'b0;
   logic       KEY = 1'b0;
   logic       UART_RXD = 1'b1;
   logic [3:0] w_RX_Byte;
   logic       w_RX_DV, o_rx_err, o_busy;

   int   checks = 0;
   int   failures = 0;
   int   viol = 0;
   bit   mon_en = 1'b0;
   logic [3:0] prev_nib = 4'h0;
   ev_t  evq[$];
   vec_t vt[12];

   uart_nibble_rx #(.CLKS_PER_BIT(CPB)) dut (
      .CLOCK_50(CLOCK_50), .KEY(KEY), .UART_RXD(UART_RXD),
      .w_RX_Byte(w_RX_Byte), .w_RX_DV(w_RX_DV), .o_rx_err(o_rx_err), .o_busy(o_busy)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   // strobe collector: overlap or a byte change without DV counts as a violation
   always @(negedge CLOCK_50) begin
      if (mon_en) begin
         if (w_RX_DV && o_rx_err) viol++;
         if (!w_RX_DV && KEY && w_RX_Byte !== prev_nib) viol++;
         if (w_RX_DV || o_rx_err) evq.push_back('{w_RX_DV, w_RX_Byte});
      end
      prev_nib = w_RX_Byte;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input bit stop);
      logic [9:0] f;
      f = {stop, d, 1'b0};
      for (int b = 0; b < 10; b++) begin
         UART_RXD = f[b];
         repeat (CPB) @(negedge CLOCK_50);
      end
      UART_RXD = 1'b1;
   endtask

   initial begin
      bit seen;
      vt[0]  = '{8'h31, 1'b1, 1'b1, 4'h1, 1'b1, 4'h1};
      vt[1]  = '{8'h32, 1'b1, 1'b1, 4'h2, 1'b1, 4'h2};
      vt[2]  = '{8'h33, 1'b1, 1'b1, 4'h3, 1'b1, 4'h3};
      vt[3]  = '{8'h61, 1'b1, 1'b1, 4'hA, 1'b1, 4'h1};
      vt[4]  = '{8'h47, 1'b1, 1'b0, 4'hA, 1'b1, 4'h7};
      vt[5]  = '{8'h38, 1'b0, 1'b0, 4'hA, 1'b0, 4'h7};
      vt[6]  = '{8'h38, 1'b1, 1'b1, 4'h8, 1'b1, 4'h8};
      vt[7]  = '{8'h46, 1'b1, 1'b1, 4'hF, 1'b1, 4'h6};
      vt[8]  = '{8'h39, 1'b1, 1'b1, 4'h9, 1'b1, 4'h9};
      vt[9]  = '{8'h00, 1'b1, 1'b0, 4'h9, 1'b1, 4'h0};
      vt[10] = '{8'h66, 1'b1, 1'b1, 4'hF, 1'b1, 4'h6};
      vt[11] = '{8'h40, 1'b1, 1'b0, 4'hF, 1'b1, 4'h0};

      repeat (20) begin
         @(negedge CLOCK_50);
         UART_RXD = ~UART_RXD;
      end
      check("rst_byte", w_RX_Byte, 4'h0);
      check("rst_dv", w_RX_DV, 1'b0);
      check("rst_err", o_rx_err, 1'b0);
      check("rst_busy", o_busy, 1'b0);
      UART_RXD = 1'b1;
      @(negedge CLOCK_50);
      KEY = 1'b1;
      mon_en = 1'b1;
      repeat (200) @(negedge CLOCK_50);
      check("idle_strobes", evq.size(), 0);
      check("idle_busy", o_busy, 1'b0);

      foreach (vt[i]) begin
         send_frame(vt[i].data, vt[i].stop);
         if (!vt[i].stop) repeat (16) @(negedge CLOCK_50);
      end
      repeat (20) @(negedge CLOCK_50);
      check("table_event_count", evq.size(), 12);
      for (int i = 0; i < 12 && i < evq.size(); i++) begin
         check($sformatf("vec%0d_dv", i), evq[i].is_dv, ASCII ? vt[i].dv_a : vt[i].dv_r);
         check($sformatf("vec%0d_byte", i), evq[i].nib, ASCII ? vt[i].nib_a : vt[i].nib_r);
      end
      check("table_final_byte", w_RX_Byte, ASCII ? 4'hF : 4'h0);

      evq.delete();
      UART_RXD = 1'b0;
      repeat (2) @(negedge CLOCK_50);
      UART_RXD = 1'b1;
      seen = 1'b0;
      repeat (5) begin
         @(negedge CLOCK_50);
         if (o_busy) seen = 1'b1;
      end
      check("glitch_busy_seen", seen, 1'b1);
      check("glitch_busy_cleared", o_busy, 1'b0);
      repeat (20) @(negedge CLOCK_50);
      check("glitch_strobes", evq.size(), 0);

      fork
         send_frame(8'h35, 1'b1);
         begin
            repeat (CPB * 5 + 4) @(negedge CLOCK_50);
            check("abort_busy_before", o_busy, 1'b1);
            KEY = 1'b0;
            #1;
            check("abort_busy", o_busy, 1'b0);
            check("abort_byte", w_RX_Byte, 4'h0);
         end
      join
      repeat (4) @(negedge CLOCK_50);
      KEY = 1'b1;
      repeat (100) @(negedge CLOCK_50);
      check("abort_strobes", evq.size(), 0);

      send_frame(8'h34, 1'b1);
      repeat (20) @(negedge CLOCK_50);
      check("recover_count", evq.size(), 1);
      if (evq.size() > 0) begin
         check("recover_dv", evq[0].is_dv, 1'b1);
         check("recover_byte", evq[0].nib, 4'h4);
      end
      check("strobe_invariants", viol, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
